pipe_irq_ctrl: RTL and testbench

- Interrupt/exception sequencer for the 5-stage pipeline.
- Turns the raw external `intterupt` pin and ID-stage undefined-instruction/eret decodes into pipeline flushes, PC redirects, EPC/cause capture and a kernel-mode flag.
- Sits beside the stall/flush hazard unit. Its flush is ORed with the hazard flush; its redirect has priority over all other PC sources in IF.

---
 rtl/pipe_irq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_irq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_irq_ctrl
// Interrupt/exception sequencer for the 5-stage pipeline. Turns the external
// interrupt pin and ID-stage undefined/eret decodes into a one-cycle pipeline
// flush plus PC redirect, captures EPC/cause, and tracks kernel mode.
//
// Build option:
//   IRQ_SYNC_EN  defined   -> two-flop synchronizer on the interrupt pin
//                              (SYNC_DEPTH = 2)
//                undefined -> single registering flop; the pin must already
//                              be synchronous to clk (SYNC_DEPTH = 1)
//
// Timing: a rising edge first sampled on clk edge 0 sets the pending flag on
// edge SYNC_DEPTH; the INT state (flush/redirect high) occupies the cycle that
// ends on edge SYNC_DEPTH+2, given the take condition holds and irq_mask = 0.
// -----------------------------------------------------------------------------
module pipe_irq_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h80000004,
   parameter logic [31:0] EXC_ADDR     = 32'h80000008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        intterupt,
   input  logic        irq_mask,
   input  logic        valid_id,
   input  logic        stall_id,
   input  logic        branch_id,
   input  logic        undef_id,
   input  logic        eret_id,
   input  logic [31:0] pcplus4_id,
   output logic        irq_flush,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        kernel_mode,
   output logic        irq_pending
);

   typedef enum logic [2:0] {
      ST_USER   = 3'd0,
      ST_INT    = 3'd1,
      ST_EXC    = 3'd2,
      ST_KERNEL = 3'd3,
      ST_RET    = 3'd4
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_INT   = 2'b01;
   localparam logic [1:0] CAUSE_UNDEF = 2'b10;

   state_t      state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  cause_q, cause_d;
   logic        kernel_mode_q, kernel_mode_d;
   logic        pending_q, pending_d;
   logic        synced_prev_q, synced_prev_d;
   logic        sync1_q, sync1_d;
   logic        irq_synced;

`ifdef IRQ_SYNC_EN
   logic        sync2_q, sync2_d;

   // Two-flop synchronizer chain for the asynchronous interrupt pin.
   always_comb begin
      sync1_d = intterupt;
      sync2_d = sync1_q;
   end

   // Synchronizer register stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign irq_synced = sync2_q;
`else
   // Single registering stage; source is assumed clk-synchronous already.
   always_comb begin
      sync1_d = intterupt;
   end

   // Input register stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
      end
   end

   assign irq_synced = sync1_q;
`endif

   logic irq_rise;
   logic take_ok;

   // Next-state, capture registers and Moore outputs decoded from state_q.
   always_comb begin
      state_d       = state_q;
      epc_d         = epc_q;
      cause_d       = cause_q;
      kernel_mode_d = kernel_mode_q;
      pending_d     = pending_q;
      synced_prev_d = irq_synced;
      irq_flush     = 1'b0;
      pc_redirect   = 1'b0;
      pc_target     = 32'h0;

      // Only a 0->1 transition of the synced pin is a new request.
      irq_rise = irq_synced & ~synced_prev_q;
      // A branch in ID is let through first so its own redirect lands.
      take_ok  = valid_id & ~stall_id & ~branch_id;

      case (state_q)
         ST_USER: begin
            // Exceptions win over interrupts and ignore the mask.
            if (undef_id && take_ok) begin
               state_d = ST_EXC;
            end else if (pending_q && !irq_mask && take_ok) begin
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            irq_flush     = 1'b1;
            pc_redirect   = 1'b1;
            pc_target     = HANDLER_ADDR;
            epc_d         = pcplus4_id - 32'd4;
            cause_d       = CAUSE_INT;
            kernel_mode_d = 1'b1;
            pending_d     = 1'b0;
            state_d       = ST_KERNEL;
         end
         ST_EXC: begin
            irq_flush     = 1'b1;
            pc_redirect   = 1'b1;
            pc_target     = EXC_ADDR;
            epc_d         = pcplus4_id - 32'd4;
            cause_d       = CAUSE_UNDEF;
            kernel_mode_d = 1'b1;
            state_d       = ST_KERNEL;
         end
         ST_KERNEL: begin
            // No nesting: interrupts and undefined opcodes are not taken here.
            if (eret_id && valid_id && !stall_id) begin
               state_d = ST_RET;
            end
         end
         ST_RET: begin
            irq_flush     = 1'b1;
            pc_redirect   = 1'b1;
            pc_target     = epc_q;
            kernel_mode_d = 1'b0;
            cause_d       = CAUSE_NONE;
            state_d       = ST_USER;
         end
         default: begin
            state_d = ST_USER;
         end
      endcase

      // A fresh edge always wins over the clear done in the INT state.
      if (irq_rise) begin
         pending_d = 1'b1;
      end
   end

   // Sequencer state and captured status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_USER;
         epc_q         <= 32'h0;
         cause_q       <= CAUSE_NONE;
         kernel_mode_q <= 1'b0;
         pending_q     <= 1'b0;
         synced_prev_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         epc_q         <= epc_d;
         cause_q       <= cause_d;
         kernel_mode_q <= kernel_mode_d;
         pending_q     <= pending_d;
         synced_prev_q <= synced_prev_d;
      end
   end

   assign epc         = epc_q;
   assign cause       = cause_q;
   assign kernel_mode = kernel_mode_q;
   assign irq_pending = pending_q;

endmodule

// File: tb/tb_pipe_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_irq_ctrl
// Directed bench for pipe_irq_ctrl. Builds with or without IRQ_SYNC_EN; the
// expected latency follows SYNC_DEPTH below. Inputs change 1 ns after a rising
// edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_pipe_irq_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        intterupt;
   logic        irq_mask;
   logic        valid_id;
   logic        stall_id;
   logic        branch_id;
   logic        undef_id;
   logic        eret_id;
   logic [31:0] pcplus4_id;
   logic        irq_flush;
   logic        pc_redirect;
   logic [31:0] pc_target;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic        kernel_mode;
   logic        irq_pending;

   int vectors    = 0;
   int miscompares = 0;

   pipe_irq_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .intterupt   (intterupt),
      .irq_mask    (irq_mask),
      .valid_id    (valid_id),
      .stall_id    (stall_id),
      .branch_id   (branch_id),
      .undef_id    (undef_id),
      .eret_id     (eret_id),
      .pcplus4_id  (pcplus4_id),
      .irq_flush   (irq_flush),
      .pc_redirect (pc_redirect),
      .pc_target   (pc_target),
      .epc         (epc),
      .cause       (cause),
      .kernel_mode (kernel_mode),
      .irq_pending (irq_pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      intterupt  = 1'b0;
      irq_mask   = 1'b0;
      valid_id   = 1'b1;
      stall_id   = 1'b0;
      branch_id  = 1'b0;
      undef_id   = 1'b0;
      eret_id    = 1'b0;
      pcplus4_id = 32'h00400014;
   endtask

   task automatic do_reset();
      set_defaults();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Outputs must all be zero while reset is held and just after release.
   task automatic test_reset();
      set_defaults();
      reset = 1'b1;
      tick();
      tick();
      vectors++; if (irq_flush !== 1'b0)     begin miscompares++; $display("FAIL rst_flush: got %b expected 0", irq_flush); end
      vectors++; if (pc_redirect !== 1'b0)   begin miscompares++; $display("FAIL rst_redirect: got %b expected 0", pc_redirect); end
      vectors++; if (pc_target !== 32'h0)    begin miscompares++; $display("FAIL rst_target: got %h expected 00000000", pc_target); end
      vectors++; if (epc !== 32'h0)          begin miscompares++; $display("FAIL rst_epc: got %h expected 00000000", epc); end
      vectors++; if (cause !== 2'b00)        begin miscompares++; $display("FAIL rst_cause: got %b expected 00", cause); end
      vectors++; if (kernel_mode !== 1'b0)   begin miscompares++; $display("FAIL rst_kernel: got %b expected 0", kernel_mode); end
      vectors++; if (irq_pending !== 1'b0)   begin miscompares++; $display("FAIL rst_pending: got %b expected 0", irq_pending); end
      reset = 1'b0;
      tick();
      vectors++; if (irq_flush !== 1'b0)     begin miscompares++; $display("FAIL rst_idle_flush: got %b expected 0", irq_flush); end
      $display("test_reset done");
   endtask

   // Edge -> INT latency, capture, level no-retrigger, second edge in
   // KERNEL, undef ignored in KERNEL, eret and INT right after RET.
   task automatic test_irq_eret();
      do_reset();
      intterupt = 1'b1;
      for (int i = 1; i <= SD + 1; i++) begin
         tick();
         vectors++; if (irq_flush !== 1'b0) begin miscompares++; $display("FAIL irq_early_flush t%0d: got %b expected 0", i, irq_flush); end
      end
      vectors++; if (irq_pending !== 1'b1) begin miscompares++; $display("FAIL irq_pending_set: got %b expected 1", irq_pending); end
      tick();
      vectors++; if (irq_flush !== 1'b1)          begin miscompares++; $display("FAIL irq_flush: got %b expected 1", irq_flush); end
      vectors++; if (pc_redirect !== 1'b1)        begin miscompares++; $display("FAIL irq_redirect: got %b expected 1", pc_redirect); end
      vectors++; if (pc_target !== 32'h80000004)  begin miscompares++; $display("FAIL irq_target: got %h expected 80000004", pc_target); end
      vectors++; if (kernel_mode !== 1'b0)        begin miscompares++; $display("FAIL irq_kernel_early: got %b expected 0", kernel_mode); end
      tick();
      vectors++; if (irq_flush !== 1'b0)          begin miscompares++; $display("FAIL krn_flush: got %b expected 0", irq_flush); end
      vectors++; if (epc !== 32'h00400010)        begin miscompares++; $display("FAIL irq_epc: got %h expected 00400010", epc); end
      vectors++; if (cause !== 2'b01)             begin miscompares++; $display("FAIL irq_cause: got %b expected 01", cause); end
      vectors++; if (kernel_mode !== 1'b1)        begin miscompares++; $display("FAIL irq_kernel: got %b expected 1", kernel_mode); end
      vectors++; if (irq_pending !== 1'b0)        begin miscompares++; $display("FAIL irq_pending_clr: got %b expected 0", irq_pending); end
      // Pin still high: level must not re-arm the request.
      repeat (SD + 2) tick();
      vectors++; if (irq_pending !== 1'b0)        begin miscompares++; $display("FAIL level_retrigger: got %b expected 0", irq_pending); end
      // Second edge while in KERNEL: latched, not taken.
      intterupt = 1'b0;
      repeat (SD + 2) tick();
      intterupt = 1'b1;
      repeat (SD + 1) tick();
      vectors++; if (irq_pending !== 1'b1)        begin miscompares++; $display("FAIL krn_pending: got %b expected 1", irq_pending); end
      tick();
      vectors++; if (irq_flush !== 1'b0)          begin miscompares++; $display("FAIL krn_no_nest: got %b expected 0", irq_flush); end
      // Undefined opcode inside the handler is ignored; EPC kept.
      undef_id   = 1'b1;
      pcplus4_id = 32'h00000100;
      tick();
      vectors++; if (irq_flush !== 1'b0)          begin miscompares++; $display("FAIL krn_undef_flush: got %b expected 0", irq_flush); end
      undef_id = 1'b0;
      tick();
      vectors++; if (epc !== 32'h00400010)        begin miscompares++; $display("FAIL krn_epc_kept: got %h expected 00400010", epc); end
      vectors++; if (cause !== 2'b01)             begin miscompares++; $display("FAIL krn_cause_kept: got %b expected 01", cause); end
      // eret
      eret_id = 1'b1;
      tick();
      vectors++; if (irq_flush !== 1'b1)          begin miscompares++; $display("FAIL ret_flush: got %b expected 1", irq_flush); end
      vectors++; if (pc_target !== 32'h00400010)  begin miscompares++; $display("FAIL ret_target: got %h expected 00400010", pc_target); end
      vectors++; if (kernel_mode !== 1'b1)        begin miscompares++; $display("FAIL ret_kernel: got %b expected 1", kernel_mode); end
      eret_id    = 1'b0;
      pcplus4_id = 32'h00400024;
      tick();
      vectors++; if (irq_flush !== 1'b0)          begin miscompares++; $display("FAIL post_ret_flush: got %b expected 0", irq_flush); end
      vectors++; if (kernel_mode !== 1'b0)        begin miscompares++; $display("FAIL post_ret_kernel: got %b expected 0", kernel_mode); end
      vectors++; if (cause !== 2'b00)             begin miscompares++; $display("FAIL post_ret_cause: got %b expected 00", cause); end
      vectors++; if (irq_pending !== 1'b1)        begin miscompares++; $display("FAIL post_ret_pending: got %b expected 1", irq_pending); end
      tick();
      vectors++; if (irq_flush !== 1'b1)          begin miscompares++; $display("FAIL irq2_flush: got %b expected 1", irq_flush); end
      vectors++; if (pc_target !== 32'h80000004)  begin miscompares++; $display("FAIL irq2_target: got %h expected 80000004", pc_target); end
      tick();
      vectors++; if (epc !== 32'h00400020)        begin miscompares++; $display("FAIL irq2_epc: got %h expected 00400020", epc); end
      vectors++; if (irq_pending !== 1'b0)        begin miscompares++; $display("FAIL irq2_pending: got %b expected 0", irq_pending); end
      $display("test_irq_eret done");
   endtask

   // Stall for two pending cycles, then a branch; INT only when all clear.
   task automatic test_deferral();
      do_reset();
      stall_id  = 1'b1;
      intterupt = 1'b1;
      for (int i = 1; i <= SD + 3; i++) begin
         tick();
         vectors++; if (irq_flush !== 1'b0) begin miscompares++; $display("FAIL defer_stall_flush t%0d: got %b expected 0", i, irq_flush); end
      end
      vectors++; if (irq_pending !== 1'b1) begin miscompares++; $display("FAIL defer_pending: got %b expected 1", irq_pending); end
      stall_id  = 1'b0;
      branch_id = 1'b1;
      tick();
      vectors++; if (irq_flush !== 1'b0) begin miscompares++; $display("FAIL defer_branch_flush: got %b expected 0", irq_flush); end
      branch_id = 1'b0;
      tick();
      vectors++; if (irq_flush !== 1'b1) begin miscompares++; $display("FAIL defer_take: got %b expected 1", irq_flush); end
      vectors++; if (pc_target !== 32'h80000004) begin miscompares++; $display("FAIL defer_target: got %h expected 80000004", pc_target); end
      $display("test_deferral done");
   endtask

   // Undefined with a pending interrupt: EXC wins, pending survives.
   task automatic test_undef_irq();
      do_reset();
      stall_id   = 1'b1;
      intterupt  = 1'b1;
      pcplus4_id = 32'h00000000;
      repeat (SD + 1) tick();
      vectors++; if (irq_pending !== 1'b1) begin miscompares++; $display("FAIL exc_pre_pending: got %b expected 1", irq_pending); end
      // Bubble in ID: undefined decode must not be taken.
      stall_id = 1'b0;
      valid_id = 1'b0;
      undef_id = 1'b1;
      tick();
      vectors++; if (irq_flush !== 1'b0) begin miscompares++; $display("FAIL exc_bubble: got %b expected 0", irq_flush); end
      valid_id = 1'b1;
      tick();
      vectors++; if (irq_flush !== 1'b1)         begin miscompares++; $display("FAIL exc_flush: got %b expected 1", irq_flush); end
      vectors++; if (pc_target !== 32'h80000008) begin miscompares++; $display("FAIL exc_target: got %h expected 80000008", pc_target); end
      undef_id = 1'b0;
      tick();
      vectors++; if (cause !== 2'b10)            begin miscompares++; $display("FAIL exc_cause: got %b expected 10", cause); end
      vectors++; if (epc !== 32'hFFFFFFFC)       begin miscompares++; $display("FAIL exc_epc_wrap: got %h expected fffffffc", epc); end
      vectors++; if (kernel_mode !== 1'b1)       begin miscompares++; $display("FAIL exc_kernel: got %b expected 1", kernel_mode); end
      vectors++; if (irq_pending !== 1'b1)       begin miscompares++; $display("FAIL exc_pending_kept: got %b expected 1", irq_pending); end
      $display("test_undef_irq done");
   endtask

   // Masked request stays pending; unmask takes it; async reset mid-KERNEL.
   task automatic test_mask_reset();
      do_reset();
      irq_mask  = 1'b1;
      intterupt = 1'b1;
      repeat (SD + 1) tick();
      vectors++; if (irq_pending !== 1'b1) begin miscompares++; $display("FAIL mask_pending: got %b expected 1", irq_pending); end
      for (int i = 1; i <= 10; i++) begin
         tick();
         vectors++; if (irq_flush !== 1'b0) begin miscompares++; $display("FAIL mask_flush t%0d: got %b expected 0", i, irq_flush); end
      end
      irq_mask = 1'b0;
      tick();
      vectors++; if (irq_flush !== 1'b1) begin miscompares++; $display("FAIL unmask_take: got %b expected 1", irq_flush); end
      tick();
      intterupt = 1'b0;
      repeat (SD + 2) tick();
      intterupt = 1'b1;
      repeat (SD + 1) tick();
      vectors++; if (kernel_mode !== 1'b1) begin miscompares++; $display("FAIL pre_rst_kernel: got %b expected 1", kernel_mode); end
      vectors++; if (irq_pending !== 1'b1) begin miscompares++; $display("FAIL pre_rst_pending: got %b expected 1", irq_pending); end
      // Mid-cycle, well away from any clock edge.
      #3;
      intterupt = 1'b0;
      reset     = 1'b1;
      #1;
      vectors++; if (kernel_mode !== 1'b0)  begin miscompares++; $display("FAIL arst_kernel: got %b expected 0", kernel_mode); end
      vectors++; if (irq_pending !== 1'b0)  begin miscompares++; $display("FAIL arst_pending: got %b expected 0", irq_pending); end
      vectors++; if (epc !== 32'h0)         begin miscompares++; $display("FAIL arst_epc: got %h expected 00000000", epc); end
      vectors++; if (cause !== 2'b00)       begin miscompares++; $display("FAIL arst_cause: got %b expected 00", cause); end
      vectors++; if (irq_flush !== 1'b0)    begin miscompares++; $display("FAIL arst_flush: got %b expected 0", irq_flush); end
      vectors++; if (pc_target !== 32'h0)   begin miscompares++; $display("FAIL arst_target: got %h expected 00000000", pc_target); end
      tick();
      reset = 1'b0;
      tick();
      vectors++; if (irq_flush !== 1'b0)    begin miscompares++; $display("FAIL post_arst_flush: got %b expected 0", irq_flush); end
      $display("test_mask_reset done");
   endtask

   initial begin
      set_defaults();
      reset = 1'b1;
      test_reset();
      test_irq_eret();
      test_deferral();
      test_undef_irq();
      test_mask_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
